alarm_bank: RTL and testbench

//  Multi-slot alarm engine for the digital clock: N programmable HH:MM:SS alarms compared against live BCD time.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/alarm_prio_enc.sv | 24 ++
 rtl/alarm_bank.sv | 182 ++++++++++++++++++
 tb/tb_alarm_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and defaults for the digital clock: BCD time word, alarm FSM states, ring/snooze defaults.
package clock_pkg;

  // {H1,H0,M1,M0,S1,S0}, one BCD digit per nibble
  typedef logic [23:0] bcd_time_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RING = 1'b1
  } alarm_state_t;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

  // Counter width that still holds max_val, never below one bit
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/alarm_prio_enc.sv
// Lowest-index-wins priority encoder over the pending alarm vector.
// Purely combinational; grant is valid when any=1.
module alarm_prio_enc #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last writer
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = IDXW'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm engine: matches armed slots against live BCD time, queues coincident alarms, snooze and auto-timeout.
// beepen rises the cycle after a matching tick; buttons are one-cycle pulses with no backpressure.
module alarm_bank
  import clock_pkg::*;
#(
  parameter int N_ALARM    = 4,
  parameter int IDXW       = 2,
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic               clk50mhz,
  input  logic               rst,
  input  logic               tick1hz,
  input  logic [23:0]        now_bcd,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [23:0]        wr_time,
  input  logic               wr_arm,
  input  logic               snooze,
  input  logic               dismiss,
  output logic               beepen,
  output logic [IDXW-1:0]    ring_idx,
  output logic [N_ALARM-1:0] armed,
  output logic               snz_act
);

  localparam int RCW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int SCW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
  localparam int NCW = cnt_width(MAX_SNOOZE);

  bcd_time_t          slot_time_q [N_ALARM];
  logic [N_ALARM-1:0] armed_q;
  logic [N_ALARM-1:0] pending_q, pending_d;
  alarm_state_t       state_q, state_d;
  logic [IDXW-1:0]    ring_idx_q, ring_idx_d;
  logic [RCW-1:0]     ring_cnt_q, ring_cnt_d;
  logic               snz_act_q, snz_act_d;
  logic [IDXW-1:0]    snz_idx_q, snz_idx_d;
  logic [SCW-1:0]     snz_tmr_q, snz_tmr_d;
  logic [NCW-1:0]     snz_cnt_q, snz_cnt_d;

  logic [N_ALARM-1:0] match_vec;
  logic [N_ALARM-1:0] snz_vec;
  logic [N_ALARM-1:0] pend_in;
  logic [IDXW-1:0]    gnt_idx;
  logic               gnt_any;
  logic               disarm_wr;
  logic               wr_disarm_ring;
  logic               snz_cancel;
  logic               snz_fire;
  logic               ring_timeout;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      match_vec[i] = tick1hz && armed_q[i] && (slot_time_q[i] == now_bcd);
    end
  end

  assign disarm_wr      = wr_en && !wr_arm;
  assign wr_disarm_ring = (state_q == ST_RING) && disarm_wr && (wr_idx == ring_idx_q);
  assign snz_cancel     = snz_act_q && disarm_wr && (wr_idx == snz_idx_q);
  assign snz_fire       = snz_act_q && tick1hz && !snz_cancel &&
                          (snz_tmr_q == SCW'(SNOOZE_SEC - 1));
  assign ring_timeout   = (state_q == ST_RING) && tick1hz &&
                          (ring_cnt_q == RCW'(RING_SEC - 1));

  always_comb begin
    snz_vec = '0;
    if (snz_fire) snz_vec[snz_idx_q] = 1'b1;
  end

  // Fresh matches and snooze expiry bypass the pending register so IDLE can start ringing this cycle
  assign pend_in = pending_q | match_vec | snz_vec;

  alarm_prio_enc #(
    .N    (N_ALARM),
    .IDXW (IDXW)
  ) u_prio (
    .req     (pend_in),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    ring_cnt_d = ring_cnt_q;
    pending_d  = pend_in;
    snz_act_d  = snz_act_q;
    snz_idx_d  = snz_idx_q;
    snz_tmr_d  = snz_tmr_q;
    snz_cnt_d  = snz_cnt_q;

    // Snooze timer runs independently of whichever alarm is ringing
    if (snz_act_q) begin
      if (snz_cancel) begin
        snz_act_d = 1'b0;
        snz_cnt_d = '0;
      end else if (snz_fire) begin
        snz_act_d = 1'b0;
      end else if (tick1hz) begin
        snz_tmr_d = snz_tmr_q + SCW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d            = ST_RING;
          ring_idx_d         = gnt_idx;
          ring_cnt_d         = '0;
          pending_d[gnt_idx] = 1'b0;
        end
      end
      ST_RING: begin
        if (wr_disarm_ring) begin
          state_d               = ST_IDLE;
          pending_d[ring_idx_q] = 1'b0;
        end else if (dismiss) begin
          state_d   = ST_IDLE;
          snz_cnt_d = '0;
        end else if (snooze) begin
          state_d = ST_IDLE;
          if ((snz_cnt_q < NCW'(MAX_SNOOZE)) && !snz_act_q) begin
            snz_act_d = 1'b1;
            snz_idx_d = ring_idx_q;
            snz_tmr_d = '0;
            snz_cnt_d = snz_cnt_q + NCW'(1);
          end else begin
            snz_cnt_d = '0;
          end
        end else if (ring_timeout) begin
          state_d   = ST_IDLE;
          snz_cnt_d = '0;
        end else if (tick1hz) begin
          ring_cnt_d = ring_cnt_q + RCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ALARM; i++) slot_time_q[i] <= '0;
      armed_q <= '0;
    end else if (wr_en) begin
      slot_time_q[wr_idx] <= wr_time;
      armed_q[wr_idx]     <= wr_arm;
    end
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      pending_q  <= '0;
      snz_act_q  <= 1'b0;
      snz_idx_q  <= '0;
      snz_tmr_q  <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ring_idx_q <= ring_idx_d;
      ring_cnt_q <= ring_cnt_d;
      pending_q  <= pending_d;
      snz_act_q  <= snz_act_d;
      snz_idx_q  <= snz_idx_d;
      snz_tmr_q  <= snz_tmr_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign beepen   = (state_q == ST_RING);
  assign ring_idx = ring_idx_q;
  assign armed    = armed_q;
  assign snz_act  = snz_act_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: match, queuing, snooze limit, priority, disarm-while-ringing, async reset.
module tb_alarm_bank;

  logic        clk50mhz = 1'b0;
  logic        rst;
  logic        tick1hz;
  logic [23:0] now_bcd;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [23:0] wr_time;
  logic        wr_arm;
  logic        snooze;
  logic        dismiss;
  logic        beepen;
  logic [1:0]  ring_idx;
  logic [3:0]  armed;
  logic        snz_act;

  int n_cmp = 0;
  int n_err = 0;

  alarm_bank dut (
    .clk50mhz (clk50mhz),
    .rst      (rst),
    .tick1hz  (tick1hz),
    .now_bcd  (now_bcd),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_time  (wr_time),
    .wr_arm   (wr_arm),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .beepen   (beepen),
    .ring_idx (ring_idx),
    .armed    (armed),
    .snz_act  (snz_act)
  );

  always #10 clk50mhz = ~clk50mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50mhz);
      #1;
    end
  endtask

  task automatic tick(input logic [23:0] t);
    now_bcd = t;
    tick1hz = 1'b1;
    @(posedge clk50mhz);
    #1;
    tick1hz = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [23:0] t);
    for (int i = 0; i < n; i++) begin
      tick(t);
      idle(1);
    end
  endtask

  task automatic prog(input logic [1:0] idx, input logic [23:0] t, input logic arm);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_time = t;
    wr_arm  = arm;
    @(posedge clk50mhz);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic press(input logic s, input logic d);
    snooze  = s;
    dismiss = d;
    @(posedge clk50mhz);
    #1;
    snooze  = 1'b0;
    dismiss = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick1hz = 1'b0; now_bcd = '0; wr_en = 1'b0; wr_idx = '0;
    wr_time = '0; wr_arm = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    #25;
    chk("rst_beepen", beepen, 0);
    chk("rst_armed", armed, 0);
    chk("rst_snz_act", snz_act, 0);
    chk("rst_ring_idx", ring_idx, 0);
    @(posedge clk50mhz); #1; rst = 1'b0;
    idle(2);

    // Single alarm, auto-timeout after 60 ticks
    prog(2'd1, 24'h070000, 1'b1);
    chk("t1_armed", armed, 4'b0010);
    idle(1);
    chk("t1_no_ring_before_tick", beepen, 0);
    tick(24'h070000);
    chk("t1_beepen_rise", beepen, 1);
    chk("t1_ring_idx", ring_idx, 1);
    ticks(59, 24'h070001);
    chk("t1_still_ring_59", beepen, 1);
    ticks(1, 24'h070002);
    chk("t1_timeout", beepen, 0);
    prog(2'd1, 24'h070000, 1'b0);

    // Coincident alarms: lowest first, one idle cycle, then the next
    prog(2'd0, 24'h120000, 1'b1);
    prog(2'd2, 24'h120000, 1'b1);
    tick(24'h120000);
    chk("t2_ring0", {beepen, 2'b0, ring_idx}, {1'b1, 2'b0, 2'd0});
    press(1'b0, 1'b1);
    chk("t2_gap", beepen, 0);
    idle(1);
    chk("t2_ring2", {beepen, 2'b0, ring_idx}, {1'b1, 2'b0, 2'd2});
    press(1'b0, 1'b1);
    prog(2'd2, 24'h120000, 1'b0);
    idle(2);
    chk("t2_idle_after", beepen, 0);

    // Three snoozes re-ring after 300 ticks; the fourth acts as dismiss
    tick(24'h120000);
    chk("t3_ring0", beepen, 1);
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      chk($sformatf("t3_snz%0d_beep", k), beepen, 0);
      chk($sformatf("t3_snz%0d_act", k), snz_act, 1);
      chk($sformatf("t3_snz%0d_cnt", k), dut.snz_cnt_q, k);
      ticks(299, 24'h120001);
      chk($sformatf("t3_snz%0d_wait", k), {beepen, snz_act}, 2'b01);
      ticks(1, 24'h120001);
      chk($sformatf("t3_snz%0d_rering", k), {beepen, snz_act, ring_idx}, {1'b1, 1'b0, 2'd0});
    end
    press(1'b1, 1'b0);
    chk("t3_4th_beep", beepen, 0);
    chk("t3_4th_act", snz_act, 0);
    chk("t3_4th_cnt", dut.snz_cnt_q, 0);
    ticks(300, 24'h120001);
    chk("t3_no_rering", beepen, 0);

    // Snooze and dismiss together: dismiss wins
    tick(24'h120000);
    press(1'b1, 1'b0);
    ticks(300, 24'h120001);
    chk("t4_rering", beepen, 1);
    chk("t4_cnt_before", dut.snz_cnt_q, 1);
    press(1'b1, 1'b1);
    chk("t4_beep", beepen, 0);
    chk("t4_act", snz_act, 0);
    chk("t4_cnt", dut.snz_cnt_q, 0);

    // Disarm the ringing slot
    prog(2'd0, 24'h120000, 1'b0);
    prog(2'd3, 24'h063000, 1'b1);
    tick(24'h063000);
    chk("t5_ring3", {beepen, 2'b0, ring_idx}, {1'b1, 2'b0, 2'd3});
    prog(2'd3, 24'h063000, 1'b0);
    chk("t5_beep_off", beepen, 0);
    chk("t5_armed", armed, 0);
    idle(2);
    chk("t5_no_queue", beepen, 0);
    tick(24'h063000);
    chk("t5_no_rering", beepen, 0);

    // Async reset mid-ring and mid-snooze
    prog(2'd1, 24'h080000, 1'b1);
    tick(24'h080000);
    chk("t6_ring", {beepen, 2'b0, ring_idx}, {1'b1, 2'b0, 2'd1});
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_ring_beep", beepen, 0);
    chk("t6_rst_ring_armed", armed, 0);
    chk("t6_rst_ring_idx", ring_idx, 0);
    #3 rst = 1'b0;
    idle(1);
    prog(2'd1, 24'h080000, 1'b1);
    tick(24'h080000);
    press(1'b1, 1'b0);
    chk("t6_snz_act", snz_act, 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_snz_act", snz_act, 0);
    chk("t6_rst_snz_armed", armed, 0);
    chk("t6_rst_snz_beep", beepen, 0);
    #3 rst = 1'b0;
    idle(2);
    tick(24'h080000);
    chk("t6_disarmed_after_rst", beepen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
